pixel_writer: RTL and testbench

- Consumer end of the line/shape coordinate stream: takes signed (x, y) pixels plus colour under a valid/oe handshake and turns them into masked word writes to a packed-pixel framebuffer port.
- Sits between shape generators (line, triangle, fill) and the framebuffer memory arbiter.
- Owns clipping, linear address calculation, slot/mask packing and memory back-pressure.

---
 rtl/gfx_pkg.sv | 31 +++
 rtl/pix_addr.sv | 38 +++
 rtl/pixel_writer.sv | 219 +++++++++++++++++++++
 tb/tb_pixel_writer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// gfx_pkg -- shared graphics constants and helpers.
//
// Holds the packed-pixel geometry derived for the default canvas
// (320x240, 4 bpp, 32-bit words) and the helpers that parameterised blocks
// (pixel_writer, fill, triangle) use to derive their own geometry and to
// test whether a signed coordinate falls on the canvas.
package gfx_pkg;

    // Pixels per memory word.
    function automatic int ppw_of(input int word, input int bpp);
        return word / bpp;
    endfunction

    // Bits needed for a linear pixel index over a width x height canvas.
    function automatic int idx_w_of(input int width, input int height);
        return $clog2(width * height);
    endfunction

    localparam int PPW   = ppw_of(32, 4);
    localparam int SLOTW = $clog2(PPW);
    localparam int IDXW  = idx_w_of(320, 240);

    // True when (px, py) lies on a w x h canvas. Callers sign-extend
    // their coordinates to 32 bits so negative values compare correctly.
    function automatic logic in_range(input logic signed [31:0] px,
                                      input logic signed [31:0] py,
                                      input int w, input int h);
        return (px >= 0) && (px < w) && (py >= 0) && (py < h);
    endfunction

endpackage

// File: rtl/pix_addr.sv
// pix_addr -- combinational clip test and packed-pixel address split.
//
// Ports:
//   x, y     in  CORDW  signed pixel coordinates
//   inrange  out 1      pixel lies on the WIDTH x HEIGHT canvas
//   addr     out ADDRW  word address  (idx >> SLOTW)
//   slot     out SLOTW  pixel slot within the word (idx low bits)
// idx = y*WIDTH + x; the value is meaningless when inrange is low.
module pix_addr
    import gfx_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int SLOTW  = 3,
    parameter int IDXW   = 17,
    parameter int ADDRW  = 14
) (
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    output logic                    inrange,
    output logic [ADDRW-1:0]        addr,
    output logic [SLOTW-1:0]        slot
);

    logic signed [31:0] x_ext;
    logic signed [31:0] y_ext;
    logic [IDXW-1:0]    idx;

    // Sign-extend so the range test and the multiply see true signed values.
    assign x_ext   = 32'(x);
    assign y_ext   = 32'(y);
    assign inrange = in_range(x_ext, y_ext, WIDTH, HEIGHT);
    assign idx     = IDXW'(y_ext * WIDTH + x_ext);
    assign addr    = ADDRW'(idx >> SLOTW);
    assign slot    = idx[SLOTW-1:0];

endmodule

// File: rtl/pixel_writer.sv
// pixel_writer -- turns a valid/oe stream of signed (x, y, colour) pixels
// into masked word writes to a packed-pixel framebuffer port.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   x, y, colour, valid   pixel input; taken on an edge with valid && oe
//   oe                    ready to the producer (combinational via mem_ready)
//   flush                 drain any held word (coalescing build only)
//   mem_addr/data/mask/we write request, held stable until mem_ready
//   mem_ready             memory accepts the write this cycle
//   clip                  one-cycle pulse: a pixel was discarded off-canvas
//   busy                  any pixel in flight or held
//
// Pipeline: S1 registers clip/address results, S2 is the write register.
// Build option PXW_COALESCE_EN: S2 holds a partial word and merges later
// pixels with the same address before issuing it.
module pixel_writer
    import gfx_pkg::*;
#(
    parameter int CORDW  = 16,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int BPP    = 4,
    parameter int WORD   = 32,
    parameter int ADDRW  = 14,
    localparam int PX_PER_WORD = ppw_of(WORD, BPP)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [CORDW-1:0] x,
    input  logic signed [CORDW-1:0] y,
    input  logic [BPP-1:0]          colour,
    input  logic                    valid,
    output logic                    oe,
    input  logic                    flush,
    output logic [ADDRW-1:0]        mem_addr,
    output logic [WORD-1:0]         mem_data,
    output logic [PX_PER_WORD-1:0]  mem_mask,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic                    clip,
    output logic                    busy
);

    localparam int SLOT_W = $clog2(PX_PER_WORD);
    localparam int IDX_W  = idx_w_of(WIDTH, HEIGHT);

    logic                   pa_inrange;
    logic [ADDRW-1:0]       pa_addr;
    logic [SLOT_W-1:0]      pa_slot;

    logic                   s1_valid_reg;
    logic                   s1_inrange_reg;
    logic [ADDRW-1:0]       s1_addr_reg;
    logic [SLOT_W-1:0]      s1_slot_reg;
    logic [BPP-1:0]         s1_colour_reg;

    logic                   mem_we_reg;
    logic [ADDRW-1:0]       mem_addr_reg;
    logic [WORD-1:0]        mem_data_reg;
    logic [PX_PER_WORD-1:0] mem_mask_reg;
    logic                   clip_reg;

    logic [PX_PER_WORD-1:0] slot_hot;
    logic [WORD-1:0]        slot_bits;
    logic [WORD-1:0]        colour_rep;
    logic [PX_PER_WORD-1:0] mask_next;
    logic [WORD-1:0]        data_next;
    logic                   s1_write;
    logic                   s2_take;
    logic                   s1_adv;
    logic                   accept;

    pix_addr #(
        .CORDW (CORDW),
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT),
        .SLOTW (SLOT_W),
        .IDXW  (IDX_W),
        .ADDRW (ADDRW)
    ) u_pix_addr (
        .x      (x),
        .y      (y),
        .inrange(pa_inrange),
        .addr   (pa_addr),
        .slot   (pa_slot)
    );

    // One-hot slot select, widened to a per-bit lane mask, and the colour
    // replicated into every lane so masking picks out the target slot.
    genvar gi;
    generate
        for (gi = 0; gi < PX_PER_WORD; gi++) begin : g_slot
            assign slot_hot[gi]                = (s1_slot_reg == SLOT_W'(gi));
            assign slot_bits[gi*BPP +: BPP]    = {BPP{slot_hot[gi]}};
            assign colour_rep[gi*BPP +: BPP]   = s1_colour_reg;
        end
    endgenerate

    assign s1_write = s1_valid_reg && s1_inrange_reg;

`ifdef PXW_COALESCE_EN
    logic held_reg;
    logic flush_pend_reg;
    logic flush_any;
    logic flush_issue;

    // While a word is held, only a same-address pixel may enter S2; a
    // different address forces the held word out and waits in S1.
    assign s2_take     = held_reg ? (s1_addr_reg == mem_addr_reg)
                                  : (!mem_we_reg || mem_ready);
    assign mask_next   = (held_reg ? mem_mask_reg : '0) | slot_hot;
    assign data_next   = ((held_reg ? mem_data_reg : '0) & ~slot_bits)
                       | (colour_rep & slot_bits);
    assign flush_any   = flush || flush_pend_reg;
    // Flush waits until S1 has nothing left to merge into the held word.
    assign flush_issue = held_reg && flush_any && !s1_write;
    assign busy        = s1_valid_reg || mem_we_reg || held_reg;
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign s2_take      = !mem_we_reg || mem_ready;
    assign mask_next    = slot_hot;
    assign data_next    = colour_rep & slot_bits;
    assign busy         = s1_valid_reg || mem_we_reg;
`endif

    // Off-canvas pixels never need S2, so they always leave S1.
    assign s1_adv = s1_valid_reg && (!s1_inrange_reg || s2_take);
    assign oe     = !s1_valid_reg || s1_adv;
    assign accept = valid && oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_inrange_reg <= 1'b0;
            s1_addr_reg    <= '0;
            s1_slot_reg    <= '0;
            s1_colour_reg  <= '0;
            clip_reg       <= 1'b0;
        end else begin
            clip_reg <= s1_valid_reg && !s1_inrange_reg;
            if (accept) begin
                s1_valid_reg   <= 1'b1;
                s1_inrange_reg <= pa_inrange;
                s1_addr_reg    <= pa_addr;
                s1_slot_reg    <= pa_slot;
                s1_colour_reg  <= colour;
            end else if (s1_adv) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

`ifdef PXW_COALESCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            mem_mask_reg   <= '0;
            held_reg       <= 1'b0;
            flush_pend_reg <= 1'b0;
        end else begin
            if (mem_we_reg && mem_ready) begin
                mem_we_reg <= 1'b0;
            end
            if (s1_write && s2_take) begin
                mem_addr_reg <= s1_addr_reg;
                mem_data_reg <= data_next;
                mem_mask_reg <= mask_next;
                if (&mask_next) begin
                    mem_we_reg <= 1'b1;
                    held_reg   <= 1'b0;
                end else begin
                    held_reg   <= 1'b1;
                end
            end else if (s1_write && held_reg) begin
                mem_we_reg <= 1'b1;
                held_reg   <= 1'b0;
            end else if (flush_issue) begin
                mem_we_reg <= 1'b1;
                held_reg   <= 1'b0;
            end
            // Remember a flush until there is a held word to drain; drop it
            // once nothing is in flight.
            flush_pend_reg <= flush_any && !flush_issue
                            && (held_reg || mem_we_reg || s1_valid_reg);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            mem_mask_reg <= '0;
        end else begin
            if (mem_we_reg && mem_ready) begin
                mem_we_reg <= 1'b0;
            end
            if (s1_write && s2_take) begin
                mem_we_reg   <= 1'b1;
                mem_addr_reg <= s1_addr_reg;
                mem_data_reg <= data_next;
                mem_mask_reg <= mask_next;
            end
        end
    end
`endif

    assign mem_we   = mem_we_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;
    assign mem_mask = mem_mask_reg;
    assign clip     = clip_reg;

endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer -- directed bench for pixel_writer with a reference model
// of canvas writes and a per-cycle compare process on the memory port.
module tb_pixel_writer;

    localparam int CORDW  = 16;
    localparam int WIDTH  = 320;
    localparam int HEIGHT = 240;
    localparam int BPP    = 4;
    localparam int WORD   = 32;
    localparam int ADDRW  = 14;
    localparam int PPW    = WORD / BPP;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b1;
    logic signed [CORDW-1:0] x = '0;
    logic signed [CORDW-1:0] y = '0;
    logic [BPP-1:0]          colour = '0;
    logic                    valid = 1'b0;
    logic                    flush = 1'b0;
    logic                    mem_ready = 1'b1;
    logic                    oe;
    logic [ADDRW-1:0]        mem_addr;
    logic [WORD-1:0]         mem_data;
    logic [PPW-1:0]          mem_mask;
    logic                    mem_we;
    logic                    clip;
    logic                    busy;

    pixel_writer #(
        .CORDW (CORDW), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .BPP   (BPP),   .WORD (WORD),  .ADDRW (ADDRW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .valid    (valid),
        .oe       (oe),
        .flush    (flush),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_mask (mem_mask),
        .mem_we   (mem_we),
        .mem_ready(mem_ready),
        .clip     (clip),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDRW-1:0] a;
        logic [PPW-1:0]   m;
        logic [WORD-1:0]  d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  exp_clips = 0;
    int  seen_clips = 0;
    int  exp_writes = 0;
    int  seen_writes = 0;
    bit  model_on = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    // Reference: where a canvas pixel lands in packed memory.
    function automatic void model_pixel(input int px, input int py, input int c);
        wr_t w;
        int  idx;
        int  s;
        if (px >= 0 && px < WIDTH && py >= 0 && py < HEIGHT) begin
            idx = py * WIDTH + px;
            s   = idx % PPW;
            w.a = ADDRW'(idx / PPW);
            w.m = PPW'(1) << s;
            w.d = WORD'(c) << (s * BPP);
            exp_q.push_back(w);
            exp_writes++;
        end else begin
            exp_clips++;
        end
    endfunction

    // Present one pixel; returns just after the edge that accepted it.
    task automatic send(input int px, input int py, input int c);
        bit got;
        got = 1'b0;
        @(negedge clk);
        x      = CORDW'(px);
        y      = CORDW'(py);
        colour = BPP'(c);
        valid  = 1'b1;
        for (int t = 0; t < 200 && !got; t++) begin
            #1 got = oe;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        #1 valid = 1'b0;
        if (!got) chk("send_timeout", 64'(got), 64'd1);
        else if (model_on) model_pixel(px, py, c);
    endtask

    // Compare process: every completed write must match the model in order;
    // a stalled write must hold its address/data/mask.
    initial begin : compare
        wr_t prev;
        bit  prev_stall;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (clip) seen_clips++;
            if (mem_we) begin
                if (prev_stall)
                    chk("stall_hold", 64'({mem_addr, mem_mask, mem_data}), 64'(prev));
                if (mem_ready) begin
                    seen_writes++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", 64'(exp_q.size()), 64'd1);
                    end else begin
                        wr_t e;
                        e = exp_q.pop_front();
                        chk("write", 64'({mem_addr, mem_mask, mem_data}), 64'(e));
                    end
                end
            end
            prev_stall = mem_we && !mem_ready;
            prev       = {mem_addr, mem_mask, mem_data};
        end
    end

    initial begin : main
        #1 rst_n = 1'b0;
        #12;
        chk("rst_we",   64'(mem_we),   64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_data", 64'(mem_data), 64'd0);
        chk("rst_mask", 64'(mem_mask), 64'd0);
        chk("rst_clip", 64'(clip),     64'd0);
        chk("rst_busy", 64'(busy),     64'd0);
        chk("rst_oe",   64'(oe),       64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef PXW_COALESCE_EN
        model_on = 1'b0;
        exp_q.push_back('{a: ADDRW'(0), m: PPW'(8'hFF), d: 32'h87654321});
        exp_q.push_back('{a: ADDRW'(1), m: PPW'(8'h01), d: 32'h00000009});
        for (int i = 0; i < 8; i++) send(i, 0, i + 1);
        send(8, 0, 9);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (8) @(negedge clk);
        chk("coalesce_writes", 64'(seen_writes), 64'd2);
        chk("coalesce_busy",   64'(busy),        64'd0);
`else
        // Single pixel: literal address/mask/data and latency.
        send(10, 2, 4'hA);
        chk("lat_edge_n", 64'(mem_we), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_edge_n1", 64'(mem_we),   64'd1);
        chk("px_addr",     64'(mem_addr), 64'd81);
        chk("px_mask",     64'(mem_mask), 64'h04);
        chk("px_data",     64'(mem_data), 64'h00000A00);
        repeat (3) @(negedge clk);

        // Off-canvas pixels.
        send(-1, 5, 1);
        send(320, 0, 2);
        send(0, 240, 3);
        repeat (4) @(negedge clk);
        #3;
        chk("clip_count", 64'(seen_clips), 64'd3);
        chk("clip_model", 64'(seen_clips), 64'(exp_clips));
        chk("clip_busy",  64'(busy),       64'd0);

        // Bottom-right corner.
        send(319, 239, 4'hF);
        @(posedge clk);
        #1;
        chk("corner_addr", 64'(mem_addr), 64'd9599);
        chk("corner_mask", 64'(mem_mask), 64'h80);
        chk("corner_data", 64'(mem_data), 64'hF0000000);
        repeat (3) @(negedge clk);

        // Stream with a five-cycle memory stall.
        fork
            begin
                for (int i = 0; i < 8; i++) send(20 + 3 * i, 10 + i, i + 1);
            end
            begin
                repeat (3) @(negedge clk);
                mem_ready = 1'b0;
                repeat (3) @(negedge clk);
                #3 chk("stall_oe", 64'(oe), 64'd0);
                repeat (2) @(negedge clk);
                mem_ready = 1'b1;
            end
        join
        repeat (5) @(negedge clk);
        #3;
        chk("stream_writes", 64'(seen_writes), 64'(exp_writes));
        chk("stream_total",  64'(seen_writes), 64'd10);

        // flush is ignored in this build.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #3 chk("flush_idle_busy", 64'(busy), 64'd0);

        // Reset while S2 is stalled on a write.
        @(negedge clk);
        mem_ready = 1'b0;
        send(5, 5, 3);
        for (int t = 0; t < 10 && !mem_we; t++) @(negedge clk);
        chk("stalled_we", 64'(mem_we), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_we",   64'(mem_we),   64'd0);
        chk("async_rst_mask", 64'(mem_mask), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("post_rst_oe",   64'(oe),   64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        #3 chk("post_rst_nowrite", 64'(seen_writes), 64'd10);
`endif
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
